fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage directly downstream of the program counter. It takes the current PC, issues one 16-bit instruction read to instruction memory over a req/ack handshake, and buffers returned {pc, instruction} pairs in a 2-entry queue for the decoder. It drives a hold signal back to the PC so the PC advances only when a fetch completes. It flushes on any taken branch, conditional jump or jal redirect.

Parameters:
ADDR_W, 16, PC / instruction address width; matches PC O_COUNT width.
INSTR_W, 16, instruction word width.
DEPTH, 2, instruction queue entries; fixed at 2, and the count register is 2 bits wide.

Ports:
clk  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
i_pc  input  ADDR_W  current PC value, the O_COUNT output of the PC
i_redirect  input  1  one-cycle pulse: taken branch, conditional jump or jal; flush
o_pc_hold  output  1  high = PC must keep its current value this cycle
o_mem_req  output  1  instruction memory read request
o_mem_addr  output  ADDR_W  read address; stable while o_mem_req is high
i_mem_ack  input  1  read complete; i_mem_rdata valid in the same cycle
i_mem_rdata  input  INSTR_W  instruction word
o_ir_valid  output  1  queue head valid
o_ir  output  INSTR_W  queue head instruction
o_ir_pc  output  ADDR_W  address of the queue head, used by the decoder for displacement and jal link
i_dec_ready  input  1  decoder accepts the head when o_ir_valid and i_dec_ready are both high

Behaviour:
- Reset (synchronous, dominates everything): state=IDLE, queue empty (count=0, pointers 0), o_mem_req=0, o_mem_addr=0, o_ir_valid=0, o_ir=0, o_ir_pc=0, o_pc_hold=1. An i_mem_ack arriving in or after the reset cycle without a new request is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - FETCH: request outstanding, result wanted.
  - DROP: request outstanding, result to be discarded.
- IDLE -> FETCH when count<DEPTH and i_redirect=0.
  - On that edge, register o_mem_addr<=i_pc and set o_mem_req<=1.
  - The request is visible from the next cycle.
- In FETCH or DROP: o_mem_req stays 1 and o_mem_addr stays stable until i_mem_ack. Ack may come in the first cycle req is high, or any cycle after.
- FETCH with ack, no redirect:
  - push {o_mem_addr, i_mem_rdata};
  - o_mem_req<=0;
  - go to IDLE.
- o_pc_hold is combinational: 0 only in a FETCH-state cycle with i_mem_ack=1 and i_redirect=0; 1 otherwise. The PC therefore advances exactly once per accepted instruction.
- Steady-state throughput: 1 instruction per 2 cycles with a zero-wait memory (request cycle, then IDLE re-issue).
- Queue:
  - o_ir_valid = (count!=0); o_ir and o_ir_pc show the head entry.
  - Pop on o_ir_valid & i_dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - No new request is issued while count==DEPTH. One outstanding request plus count<=1 guarantees the queue never overflows.
- Redirect (i_redirect=1), with priority over push and pop:
  - queue cleared to count=0 at the edge;
  - any i_mem_ack in that cycle is discarded;
  - FETCH without ack -> DROP;
  - FETCH with ack -> IDLE;
  - DROP stays DROP until ack; IDLE stays IDLE;
  - no new request is issued in the redirect cycle.
  - The PC loads its own target on redirect and ignores o_pc_hold in that cycle.
- DROP with ack: data discarded, o_mem_req<=0, go to IDLE. The next fetch uses the redirected i_pc.
- Mid-operation reset: an outstanding request is abandoned (o_mem_req=0 next cycle). Instruction memory shares RESET, so it cancels the transaction as well.
- Widths: no arithmetic on addresses. o_ir_pc is the exact address sent to memory; the stage computes no wrap. The PC owns 16-bit wrap at 0xFFFF->0x0000.

Decomposition:
- Shared CPU package holds:
  - ADDR_W, INSTR_W;
  - FSM state encoding (IDLE=2'd0, FETCH=2'd1, DROP=2'd2);
  - the {pc, instr} queue entry width (ADDR_W+INSTR_W).
- One sub-module: fetch_queue, a 2-entry synchronous FIFO with push, pop, clear, count, head outputs, and clear>push>pop priority. fetch_stage holds the FSM and handshake only.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), i_pc=0x0010, i_dec_ready=1:
  - req at cycle 1 with addr 0x0010;
  - o_pc_hold=0 at cycle 1 only;
  - o_ir_valid with o_ir_pc=0x0010 at cycle 2;
  - next req addr = 0x0011.
- Memory ack delayed 3 cycles: o_mem_addr stable and o_pc_hold=1 for all 3 wait cycles; a single push on ack.
- i_dec_ready=0, fetches at 0x0020 and 0x0021: count reaches 2, o_mem_req stays 0 afterwards. Raise ready: pops 0x0020 then 0x0021 in order, then fetching resumes.
- Redirect while a request to 0x0030 is outstanding: state goes to DROP, queue empties. Late ack data (0xBEEF) never appears on o_ir. Next req uses the new i_pc=0x0080.
- Redirect in the same cycle as ack and dec_ready with 1 entry queued: count=0 next cycle, no push, o_pc_hold=1.
- RESET asserted while FETCH is outstanding: next cycle o_mem_req=0, o_ir_valid=0, state IDLE, o_pc_hold=1. A stale ack after reset is ignored.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, fetch FSM encoding and queue entry layout.
package fetch_stage_pkg;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 2;
    localparam int ENTRY_W = ADDR_W + INSTR_W;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: PC, instruction memory and decoder signals of the fetch stage.
interface fetch_stage_if;
    import fetch_stage_pkg::*;
    logic [ADDR_W-1:0]  i_pc;
    logic               i_redirect;
    logic               o_pc_hold;
    logic               o_mem_req;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic               i_mem_ack;
    logic [INSTR_W-1:0] i_mem_rdata;
    logic               o_ir_valid;
    logic [INSTR_W-1:0] o_ir;
    logic [ADDR_W-1:0]  o_ir_pc;
    logic               i_dec_ready;
    modport master (
        input  i_pc, i_redirect, i_mem_ack, i_mem_rdata, i_dec_ready,
        output o_pc_hold, o_mem_req, o_mem_addr, o_ir_valid, o_ir, o_ir_pc
    );
    modport slave (
        output i_pc, i_redirect, i_mem_ack, i_mem_rdata, i_dec_ready,
        input  o_pc_hold, o_mem_req, o_mem_addr, o_ir_valid, o_ir, o_ir_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {pc, instr} pairs; clear beats push beats pop.
module fetch_queue
    import fetch_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  entry_t     din,
    output logic [1:0] count,
    output entry_t     head
);
    entry_t mem [DEPTH];
    logic   wr_ptr, rd_ptr;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: issues one instruction read per PC step and queues results for decode.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input logic           clk,
    input logic           RESET,
    fetch_stage_if.master bus
);
    state_t     state, state_next;
    logic       launch, push, pop;
    logic [1:0] count;
    entry_t     din, head;
    always_ff @(posedge clk) begin
        if (RESET) begin
            state          <= IDLE;
            bus.o_mem_addr <= '0;
        end else begin
            state <= state_next;
            if (launch) bus.o_mem_addr <= bus.i_pc;
        end
    end
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                launch     = !bus.i_redirect && count < 2'(DEPTH);
                state_next = launch ? FETCH : IDLE;
            end
            FETCH: begin
                push       = bus.i_mem_ack && !bus.i_redirect;
                state_next = bus.i_mem_ack ? IDLE : bus.i_redirect ? DROP : FETCH;
            end
            DROP:    state_next = bus.i_mem_ack ? IDLE : DROP;
            default: state_next = IDLE;
        endcase
    end
    // The PC advances exactly when a wanted instruction lands in the queue.
    assign bus.o_pc_hold  = !push;
    assign bus.o_mem_req  = state != IDLE;
    assign bus.o_ir_valid = count != 2'd0;
    assign bus.o_ir       = head.instr;
    assign bus.o_ir_pc    = head.pc;
    assign pop            = bus.o_ir_valid && bus.i_dec_ready;
    assign din            = '{pc: bus.o_mem_addr, instr: bus.i_mem_rdata};
    fetch_queue u_queue (
        .clk   (clk),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .clear (bus.i_redirect),
        .din   (din),
        .count (count),
        .head  (head)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, corner sequences and a randomized scoreboard run.
module tb_fetch_stage;
    import fetch_stage_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    fetch_stage_if bus ();
    fetch_stage dut (.clk(clk), .RESET(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        req;
        logic [15:0] addr;
        logic        hold;
        logic        valid;
        logic [15:0] ir_pc;
        logic [15:0] ir;
    } vec_t;

    function automatic vec_t mk(logic [15:0] pc, logic ack, logic [15:0] rdata, logic ready,
                                logic req, logic [15:0] addr, logic hold, logic valid,
                                logic [15:0] ir_pc, logic [15:0] ir);
        mk = '{pc, ack, rdata, ready, req, addr, hold, valid, ir_pc, ir};
    endfunction

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [15:0] pc, logic ack, logic [15:0] rdata, logic ready, logic redirect);
        bus.i_pc        = pc;
        bus.i_mem_ack   = ack;
        bus.i_mem_rdata = rdata;
        bus.i_dec_ready = ready;
        bus.i_redirect  = redirect;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_req", bus.o_mem_req, 0);
        chk("rst_addr", bus.o_mem_addr, 0);
        chk("rst_valid", bus.o_ir_valid, 0);
        chk("rst_ir", bus.o_ir, 0);
        chk("rst_ir_pc", bus.o_ir_pc, 0);
        chk("rst_hold", bus.o_pc_hold, 1);
        cyc();
        reset = 1'b0;
    endtask

    vec_t tbl [15];

    initial begin
        tbl[0]  = mk(16'h0010, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
        tbl[1]  = mk(16'h0010, 1, 16'h1234, 1, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000);
        tbl[2]  = mk(16'h0011, 0, 16'h0000, 1, 0, 16'h0010, 1, 1, 16'h0010, 16'h1234);
        tbl[3]  = mk(16'h0011, 1, 16'h5678, 1, 1, 16'h0011, 0, 0, 16'h0000, 16'h0000);
        tbl[4]  = mk(16'h0020, 0, 16'h0000, 0, 0, 16'h0011, 1, 1, 16'h0011, 16'h5678);
        tbl[5]  = mk(16'h0020, 1, 16'hAAAA, 0, 1, 16'h0020, 0, 1, 16'h0011, 16'h5678);
        tbl[6]  = mk(16'h0021, 0, 16'h0000, 0, 0, 16'h0020, 1, 1, 16'h0011, 16'h5678);
        tbl[7]  = mk(16'h0021, 0, 16'h0000, 0, 0, 16'h0020, 1, 1, 16'h0011, 16'h5678);
        tbl[8]  = mk(16'h0021, 0, 16'h0000, 1, 0, 16'h0020, 1, 1, 16'h0011, 16'h5678);
        tbl[9]  = mk(16'h0021, 0, 16'h0000, 0, 0, 16'h0020, 1, 1, 16'h0020, 16'hAAAA);
        tbl[10] = mk(16'h0021, 1, 16'hBBBB, 0, 1, 16'h0021, 0, 1, 16'h0020, 16'hAAAA);
        tbl[11] = mk(16'h0022, 0, 16'h0000, 0, 0, 16'h0021, 1, 1, 16'h0020, 16'hAAAA);
        tbl[12] = mk(16'h0022, 0, 16'h0000, 1, 0, 16'h0021, 1, 1, 16'h0020, 16'hAAAA);
        tbl[13] = mk(16'h0022, 0, 16'h0000, 1, 0, 16'h0021, 1, 1, 16'h0021, 16'hBBBB);
        tbl[14] = mk(16'h0022, 0, 16'h0000, 1, 1, 16'h0022, 1, 0, 16'h0000, 16'h0000);

        // zero-wait fetch, then back-pressure filling the queue
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].pc, tbl[i].ack, tbl[i].rdata, tbl[i].ready, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl_req[%0d]", i), bus.o_mem_req, tbl[i].req);
            chk($sformatf("tbl_addr[%0d]", i), bus.o_mem_addr, tbl[i].addr);
            chk($sformatf("tbl_hold[%0d]", i), bus.o_pc_hold, tbl[i].hold);
            chk($sformatf("tbl_valid[%0d]", i), bus.o_ir_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                chk($sformatf("tbl_ir_pc[%0d]", i), bus.o_ir_pc, tbl[i].ir_pc);
                chk($sformatf("tbl_ir[%0d]", i), bus.o_ir, tbl[i].ir);
            end
            cyc();
        end

        // ack delayed by three cycles
        do_reset();
        drive(16'h0040, 0, 16'h0, 0, 0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("dly_req", bus.o_mem_req, 1);
            chk("dly_addr", bus.o_mem_addr, 16'h0040);
            chk("dly_hold", bus.o_pc_hold, 1);
            cyc();
        end
        drive(16'h0040, 1, 16'h4444, 0, 0);
        @(negedge clk);
        chk("dly_ack_hold", bus.o_pc_hold, 0);
        cyc();
        drive(16'h0041, 0, 16'h0, 1, 0);
        @(negedge clk);
        chk("dly_valid", bus.o_ir_valid, 1);
        chk("dly_ir_pc", bus.o_ir_pc, 16'h0040);
        chk("dly_ir", bus.o_ir, 16'h4444);
        cyc();
        @(negedge clk);
        chk("dly_single_push", bus.o_ir_valid, 0);
        chk("dly_next_addr", bus.o_mem_addr, 16'h0041);

        // redirect while a request is outstanding: late data dropped
        do_reset();
        drive(16'h0030, 0, 16'h0, 1, 0);
        cyc();
        drive(16'h0030, 0, 16'h0, 1, 1);
        @(negedge clk);
        chk("drop_req", bus.o_mem_req, 1);
        chk("drop_redir_hold", bus.o_pc_hold, 1);
        cyc();
        drive(16'h0080, 0, 16'h0, 1, 0);
        @(negedge clk);
        chk("drop_still_req", bus.o_mem_req, 1);
        chk("drop_addr", bus.o_mem_addr, 16'h0030);
        cyc();
        drive(16'h0080, 1, 16'hBEEF, 1, 0);
        @(negedge clk);
        chk("drop_ack_hold", bus.o_pc_hold, 1);
        cyc();
        drive(16'h0080, 0, 16'h0, 1, 0);
        @(negedge clk);
        chk("drop_no_push", bus.o_ir_valid, 0);
        chk("drop_idle", bus.o_mem_req, 0);
        cyc();
        drive(16'h0080, 1, 16'h8888, 1, 0);
        @(negedge clk);
        chk("drop_new_addr", bus.o_mem_addr, 16'h0080);
        chk("drop_new_hold", bus.o_pc_hold, 0);
        cyc();
        drive(16'h0081, 0, 16'h0, 1, 0);
        @(negedge clk);
        chk("drop_new_ir_pc", bus.o_ir_pc, 16'h0080);
        chk("drop_new_ir", bus.o_ir, 16'h8888);

        // redirect together with ack and decoder ready, one entry queued
        do_reset();
        drive(16'h0050, 0, 16'h0, 0, 0);
        cyc();
        drive(16'h0050, 1, 16'h5050, 0, 0);
        @(negedge clk);
        chk("rack_first_hold", bus.o_pc_hold, 0);
        cyc();
        drive(16'h0051, 0, 16'h0, 0, 0);
        @(negedge clk);
        chk("rack_queued", bus.o_ir_valid, 1);
        cyc();
        drive(16'h0051, 1, 16'h5151, 1, 1);
        @(negedge clk);
        chk("rack_addr", bus.o_mem_addr, 16'h0051);
        chk("rack_hold", bus.o_pc_hold, 1);
        cyc();
        drive(16'h0090, 0, 16'h0, 1, 0);
        @(negedge clk);
        chk("rack_cleared", bus.o_ir_valid, 0);
        chk("rack_idle", bus.o_mem_req, 0);
        cyc();
        @(negedge clk);
        chk("rack_next_addr", bus.o_mem_addr, 16'h0090);

        // reset while a fetch is outstanding, stale ack afterwards
        do_reset();
        drive(16'h0060, 0, 16'h0, 1, 0);
        cyc();
        @(negedge clk);
        chk("mrst_req", bus.o_mem_req, 1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(16'h0060, 1, 16'hDEAD, 1, 0);
        @(negedge clk);
        chk("mrst_req_off", bus.o_mem_req, 0);
        chk("mrst_valid", bus.o_ir_valid, 0);
        chk("mrst_hold", bus.o_pc_hold, 1);
        cyc();
        drive(16'h0060, 0, 16'h0, 1, 0);
        @(negedge clk);
        chk("mrst_stale_ignored", bus.o_ir_valid, 0);
        chk("mrst_refetch", bus.o_mem_req, 1);
        cyc();
        @(negedge clk);
        chk("mrst_still_empty", bus.o_ir_valid, 0);
        cyc();

        // randomized run against a transaction-level scoreboard
        begin
            logic [31:0] q [$];
            logic [15:0] pc, prev_pc, prev_addr, req_pc;
            logic        wanted, prev_req, prev_ack, prev_redir, prev_rst, exp_req, push_e;
            logic        rdy, rdr, ak;
            int          prev_size;
            do_reset();
            pc = 16'($urandom);
            wanted = 1'b0;
            prev_rst = 1'b1;
            prev_req = 1'b0;
            prev_ack = 1'b0;
            prev_redir = 1'b0;
            prev_size = 0;
            prev_pc = '0;
            prev_addr = '0;
            req_pc = '0;
            for (int n = 0; n < 3000; n++) begin
                rdy = $urandom_range(0, 3) != 0;
                rdr = $urandom_range(0, 11) == 0;
                ak = bus.o_mem_req && $urandom_range(0, 2) == 0;
                drive(pc, ak, ak ? mem_word(bus.o_mem_addr) : 16'($urandom), rdy, rdr);
                @(negedge clk);
                exp_req = prev_rst ? 1'b0 : prev_req ? !prev_ack : (!prev_redir && prev_size < 2);
                chk("rnd_req", bus.o_mem_req, exp_req);
                if (bus.o_mem_req && !prev_req) begin
                    wanted = 1'b1;
                    req_pc = prev_pc;
                    chk("rnd_launch_addr", bus.o_mem_addr, prev_pc);
                end else if (bus.o_mem_req) begin
                    chk("rnd_addr_stable", bus.o_mem_addr, prev_addr);
                end
                push_e = bus.o_mem_req && wanted && ak && !rdr;
                chk("rnd_hold", bus.o_pc_hold, !push_e);
                chk("rnd_valid", bus.o_ir_valid, q.size() != 0);
                if (q.size() != 0) chk("rnd_head", {bus.o_ir_pc, bus.o_ir}, q[0]);
                prev_rst = 1'b0;
                prev_req = bus.o_mem_req;
                prev_ack = ak;
                prev_redir = rdr;
                prev_size = q.size();
                prev_pc = pc;
                prev_addr = bus.o_mem_addr;
                if (rdr) begin
                    q.delete();
                    wanted = 1'b0;
                    pc = 16'($urandom);
                end else begin
                    if (q.size() != 0 && rdy) void'(q.pop_front());
                    if (push_e) begin
                        q.push_back({req_pc, mem_word(req_pc)});
                        pc = pc + 16'd1;
                    end
                end
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
